mem_access_unit: RTL and testbench

//  Load/store front end between the datapath and the byte-addressed Memory block.

---
 rtl/mem_access_unit_if.sv | 23 ++
 rtl/mem_access_unit.sv | 113 +++++++++++
 tb/tb_mem_access_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response handshake bundle between datapath and mem_access_unit
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_sext;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_sext, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_sext, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store front end with alignment/range checks for the byte-addressed Memory
module mem_access_unit #(
    parameter int MEM_BYTES = 100
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_unit_if.slave   bus,
    output logic [15:0]        mem_addr,
    output logic [15:0]        mem_wword,
    output logic [7:0]         mem_wbyte,
    output logic [1:0]         mem_memw,
    input  logic [15:0]        mem_word,
    input  logic [7:0]         mem_byte
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_nxt;
    logic [1:0]  op_q;
    logic        sext_q;
    logic        req_err;
    logic [16:0] addr_ext;
    logic [16:0] addr_p1;

    // 17-bit arithmetic so addr+1 at 0xFFFF cannot wrap below the range limit
    always_comb begin
        addr_ext = {1'b0, bus.req_addr};
        addr_p1  = addr_ext + 17'd1;
        if (bus.req_op[0])
            req_err = (bus.req_addr == 16'd0) || (addr_ext >= 17'(MEM_BYTES));
        else
            req_err = bus.req_addr[0] || (addr_p1 >= 17'(MEM_BYTES));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        mem_memw       = 2'b00;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid)
                    state_nxt = req_err ? RESP : ACCESS;
            end
            ACCESS: begin
                if (op_q[1])
                    mem_memw = op_q[0] ? 2'b01 : 2'b10;
                state_nxt = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory serves the byte at Addr+1, so byte accesses present addr-1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q           <= 2'b00;
            sext_q         <= 1'b0;
            mem_addr       <= 16'h0000;
            mem_wword      <= 16'h0000;
            mem_wbyte      <= 8'h00;
            bus.resp_rdata <= 16'h0000;
            bus.resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q   <= bus.req_op;
                        sext_q <= bus.req_sext;
                        if (req_err) begin
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= 16'h0000;
                        end else begin
                            mem_addr <= bus.req_op[0] ? bus.req_addr - 16'd1 : bus.req_addr;
                            if (bus.req_op == 2'b10)
                                mem_wword <= bus.req_wdata;
                            if (bus.req_op == 2'b11)
                                mem_wbyte <= bus.req_wdata[7:0];
                        end
                    end
                end
                ACCESS: begin
                    bus.resp_err <= 1'b0;
                    case (op_q)
                        2'b00:   bus.resp_rdata <= mem_word;
                        2'b01:   bus.resp_rdata <= sext_q ? {{8{mem_byte[7]}}, mem_byte}
                                                          : {8'h00, mem_byte};
                        default: bus.resp_rdata <= 16'h0000;
                    endcase
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_rdata <= 16'h0000;
                        bus.resp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit with a behavioural Memory
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] mem_addr;
    logic [15:0] mem_wword;
    logic [7:0]  mem_wbyte;
    logic [1:0]  mem_memw;
    logic [15:0] mem_word;
    logic [7:0]  mem_byte;
    logic [7:0]  mem [0:255];

    int n_vec  = 0;
    int n_miss = 0;

    mem_access_unit_if bus ();

    mem_access_unit #(.MEM_BYTES(100)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .mem_addr  (mem_addr),
        .mem_wword (mem_wword),
        .mem_wbyte (mem_wbyte),
        .mem_memw  (mem_memw),
        .mem_word  (mem_word),
        .mem_byte  (mem_byte)
    );

    always #5 clk = ~clk;

    assign mem_word = {mem[mem_addr[7:0]], mem[mem_addr[7:0] + 8'd1]};
    assign mem_byte = mem[mem_addr[7:0] + 8'd1];

    always @(posedge clk) begin
        if (mem_memw == 2'b10) begin
            mem[mem_addr[7:0]]         <= mem_wword[15:8];
            mem[mem_addr[7:0] + 8'd1]  <= mem_wword[7:0];
        end else if (mem_memw == 2'b01) begin
            mem[mem_addr[7:0] + 8'd1]  <= mem_wbyte;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic [1:0] op, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic sext,
                          input logic [15:0] exp_rdata, input logic exp_err,
                          input logic [15:0] exp_maddr, input logic [1:0] exp_memw);
        int          lat;
        int          wcnt;
        logic [1:0]  wseen;
        logic [15:0] aseen;
        @(negedge clk);
        check({tag, ":req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_sext  = sext;
        wcnt  = 0;
        wseen = 2'b00;
        aseen = 16'h0000;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            if (mem_memw != 2'b00) begin
                wcnt++;
                wseen = mem_memw;
            end
            aseen = mem_addr;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ":latency"}, 32'(lat), exp_err ? 32'd1 : 32'd2);
        check({tag, ":rdata"},   32'(bus.resp_rdata), 32'(exp_rdata));
        check({tag, ":err"},     32'(bus.resp_err), 32'(exp_err));
        check({tag, ":memw_cycles"}, 32'(wcnt), (exp_memw != 2'b00) ? 32'd1 : 32'd0);
        check({tag, ":memw"},    32'(wseen), 32'(exp_memw));
        check({tag, ":memw_resp"}, 32'(mem_memw), 32'd0);
        if (!exp_err)
            check({tag, ":mem_addr"}, 32'(aseen), 32'(exp_maddr));
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        check({tag, ":resp_done"}, 32'(bus.resp_valid), 32'd0);
    endtask

    initial begin
        int bad;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[4]  = 8'h12;
        mem[5]  = 8'h34;
        mem[7]  = 8'hAD;
        mem[98] = 8'h80;
        mem[99] = 8'h7E;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'b00;
        bus.req_addr   = 16'h0000;
        bus.req_wdata  = 16'h0000;
        bus.req_sext   = 1'b0;
        bus.resp_ready = 1'b0;

        #12;
        check("rst:req_ready",  32'(bus.req_ready),  32'd1);
        check("rst:resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst:resp_err",   32'(bus.resp_err),   32'd0);
        check("rst:resp_rdata", 32'(bus.resp_rdata), 32'd0);
        check("rst:mem_addr",   32'(mem_addr),       32'd0);
        check("rst:mem_wword",  32'(mem_wword),      32'd0);
        check("rst:mem_wbyte",  32'(mem_wbyte),      32'd0);
        check("rst:mem_memw",   32'(mem_memw),       32'd0);
        @(negedge clk);
        rst = 1'b1;

        do_req("lw4",     2'b00, 16'h0004, 16'h0000, 1'b0, 16'h1234, 1'b0, 16'h0004, 2'b00);
        do_req("lb7s",    2'b01, 16'h0007, 16'h0000, 1'b1, 16'hFFAD, 1'b0, 16'h0006, 2'b00);
        do_req("lb7z",    2'b01, 16'h0007, 16'h0000, 1'b0, 16'h00AD, 1'b0, 16'h0006, 2'b00);
        do_req("sw10",    2'b10, 16'h0010, 16'hA55A, 1'b0, 16'h0000, 1'b0, 16'h0010, 2'b10);
        do_req("lw10a",   2'b00, 16'h0010, 16'h0000, 1'b0, 16'hA55A, 1'b0, 16'h0010, 2'b00);
        do_req("sb11",    2'b11, 16'h0011, 16'h00C3, 1'b0, 16'h0000, 1'b0, 16'h0010, 2'b01);
        do_req("lw10b",   2'b00, 16'h0010, 16'h0000, 1'b0, 16'hA5C3, 1'b0, 16'h0010, 2'b00);
        do_req("lw5err",  2'b00, 16'h0005, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 2'b00);
        do_req("lb0err",  2'b01, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h0000, 2'b00);
        do_req("lw63err", 2'b00, 16'h0063, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 2'b00);
        do_req("sb64err", 2'b11, 16'h0064, 16'h00FF, 1'b0, 16'h0000, 1'b1, 16'h0000, 2'b00);
        do_req("swFFerr", 2'b10, 16'hFFFE, 16'h1111, 1'b0, 16'h0000, 1'b1, 16'h0000, 2'b00);
        do_req("lw62",    2'b00, 16'h0062, 16'h0000, 1'b0, 16'h807E, 1'b0, 16'h0062, 2'b00);
        do_req("lb63",    2'b01, 16'h0063, 16'h0000, 1'b1, 16'h007E, 1'b0, 16'h0062, 2'b00);
        do_req("lw10c",   2'b00, 16'h0010, 16'h0000, 1'b0, 16'hA5C3, 1'b0, 16'h0010, 2'b00);

        // hold resp_ready low for 5 cycles on a load response
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b00;
        bus.req_addr  = 16'h0004;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 16'h1234 || bus.req_ready !== 1'b0)
                bad++;
            @(posedge clk); #1;
        end
        check("stall:bad_cycles", 32'(bad), 32'd0);
        check("stall:rdata",      32'(bus.resp_rdata), 32'h1234);
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        check("stall:released", 32'(bus.resp_valid), 32'd0);

        // reset asserted during the ACCESS cycle of a store
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b10;
        bus.req_addr  = 16'h0020;
        bus.req_wdata = 16'hBEEF;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("rstmid:memw_before", 32'(mem_memw), 32'd2);
        rst = 1'b0;
        #1;
        check("rstmid:memw",       32'(mem_memw),       32'd0);
        check("rstmid:req_ready",  32'(bus.req_ready),  32'd1);
        check("rstmid:resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rstmid:mem_addr",   32'(mem_addr),       32'd0);
        @(negedge clk);
        rst = 1'b1;
        do_req("lw20",    2'b00, 16'h0020, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0020, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
